// File: rtl/fp32_pkg.sv
// fp32_pkg: definitions shared by the FP32 arithmetic blocks (multiplier, divider).
//   Field widths, exponent bias, the canonical quiet NaN, an operand class
//   enum and a classify function. Subnormal encodings classify as FP_ZERO.
package fp32_pkg;

  localparam int EXP_W  = 8;    // exponent field width
  localparam int MAN_W  = 23;   // stored fraction width
  localparam int SIG_W  = 24;   // significand width including hidden bit
  localparam int PROD_W = 48;   // full significand product width
  localparam int EXPS_W = 10;   // signed working exponent width

  localparam logic signed [EXPS_W-1:0] BIAS    = 10'sd127;
  localparam logic [EXP_W-1:0]         EXP_MAX = 8'hFF;
  localparam logic [31:0]              QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_t;

  // Classify an FP32 encoding; zero exponent (zero or subnormal) is treated as zero.
  function automatic fp_class_t classify(input logic [31:0] v);
    fp_class_t c;
    if (v[30:23] == EXP_MAX) begin
      if (v[22:0] != 23'd0) begin
        c = FP_NAN;
      end else begin
        c = FP_INF;
      end
    end else if (v[30:23] == 8'h00) begin
      c = FP_ZERO;
    end else begin
      c = FP_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp32_round_rne.sv
// fp32_round_rne: combinational round-to-nearest-even for a normalised significand.
//   mant     : 24-bit significand, hidden bit in [23]
//   guard    : first bit below the kept significand
//   sticky   : OR of all remaining lower bits
//   exp_in   : signed working exponent
//   mant_out : rounded 23-bit fraction
//   exp_out  : exponent, bumped when rounding carries out of the significand
module fp32_round_rne
  import fp32_pkg::*;
(
  input  logic [SIG_W-1:0]         mant,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic signed [EXPS_W-1:0] exp_in,
  output logic [MAN_W-1:0]         mant_out,
  output logic signed [EXPS_W-1:0] exp_out
);

  logic             inc_s;
  logic [SIG_W:0]   sum_s;

  // Round-half-to-even increment, then renormalise if the significand overflowed.
  always_comb begin
    inc_s = guard & (sticky | mant[0]);
    sum_s = {1'b0, mant} + {{SIG_W{1'b0}}, inc_s};
    if (sum_s[SIG_W]) begin
      // Carry out means the value became exactly 2.0 x 2^E: shift right by one.
      mant_out = sum_s[SIG_W-1:1];
      exp_out  = exp_in + 10'sd1;
    end else begin
      mant_out = sum_s[MAN_W-1:0];
      exp_out  = exp_in;
    end
  end

endmodule

// File: rtl/fp32_multiplier.sv
// fp32_multiplier: multi-cycle IEEE-754 single-precision multiplier.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   A, B   : operands, latched when En=1 in IDLE
//   En     : start request, ignored while busy
//   Result : product, held until the next completion
//   Ready  : one-cycle completion pulse
//   NaN    : high with Ready when Result is the canonical NaN
// Special operands finish in 2 edges; normal operands take 5+MUL_STAGES edges.
// No subnormal inputs or outputs: both are flushed to signed zero.
module fp32_multiplier
  import fp32_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        En,
  output logic [31:0] Result,
  output logic        Ready,
  output logic        NaN
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLASSIFY  = 3'd1,
    MUL_ISSUE = 3'd2,
    MUL_WAIT  = 3'd3,
    NORMALIZE = 3'd4,
    ROUND     = 3'd5,
    PACK      = 3'd6
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(MUL_STAGES - 1);

  state_t                   state_r;
  logic [31:0]              a_r;
  logic [31:0]              b_r;
  logic                     sign_r;
  logic signed [EXPS_W-1:0] exp_r;
  logic [SIG_W-1:0]         mul_a_r;
  logic [SIG_W-1:0]         mul_b_r;
  logic [1:0]               cnt_r;
  logic [SIG_W-1:0]         norm_man_r;
  logic                     norm_g_r;
  logic                     norm_s_r;
  logic signed [EXPS_W-1:0] norm_exp_r;
  logic [31:0]              res_next_r;
  logic                     nan_next_r;
  logic [31:0]              result_r;
  logic                     ready_r;
  logic                     nan_r;

  (* use_dsp = "yes" *) logic [PROD_W-1:0] prod_pipe_r [MUL_STAGES];

  fp_class_t                cls_a_s;
  fp_class_t                cls_b_s;
  logic                     special_s;
  logic [31:0]              special_res_s;
  logic                     special_nan_s;
  logic signed [EXPS_W-1:0] exp_sum_s;
  logic [PROD_W-1:0]        prod_s;
  logic [PROD_W-1:0]        prod_out_s;
  logic [SIG_W-1:0]         nrm_man_s;
  logic                     nrm_g_s;
  logic                     nrm_s_s;
  logic signed [EXPS_W-1:0] nrm_exp_s;
  logic [MAN_W-1:0]         rnd_man_s;
  logic signed [EXPS_W-1:0] rnd_exp_s;
  logic [31:0]              final_res_s;

  assign Result = result_r;
  assign Ready  = ready_r;
  assign NaN    = nan_r;

  // Operand classification and special-case result, in priority order.
  always_comb begin
    cls_a_s       = classify(a_r);
    cls_b_s       = classify(b_r);
    special_s     = 1'b1;
    special_nan_s = 1'b0;
    special_res_s = {a_r[31] ^ b_r[31], 31'd0};
    if ((cls_a_s == FP_NAN) || (cls_b_s == FP_NAN)) begin
      special_res_s = QNAN;
      special_nan_s = 1'b1;
    end else if (((cls_a_s == FP_INF) && (cls_b_s == FP_ZERO)) ||
                 ((cls_a_s == FP_ZERO) && (cls_b_s == FP_INF))) begin
      special_res_s = QNAN;
      special_nan_s = 1'b1;
    end else if ((cls_a_s == FP_INF) || (cls_b_s == FP_INF)) begin
      special_res_s = {a_r[31] ^ b_r[31], EXP_MAX, 23'd0};
    end else if ((cls_a_s == FP_ZERO) || (cls_b_s == FP_ZERO)) begin
      special_res_s = {a_r[31] ^ b_r[31], 31'd0};
    end else begin
      special_s = 1'b0;
    end
    // Biased exponents are 1..254 here, so the signed sum stays well inside 10 bits.
    exp_sum_s = $signed({2'b00, a_r[30:23]}) + $signed({2'b00, b_r[30:23]}) - BIAS;
  end

  // Full-width significand product feeding the registered multiplier.
  always_comb begin
    prod_s     = {{SIG_W{1'b0}}, mul_a_r} * {{SIG_W{1'b0}}, mul_b_r};
    prod_out_s = prod_pipe_r[MUL_STAGES-1];
  end

  // Registered multiplier pipeline, free running; the FSM times when its output is used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_pipe_r[i] <= {PROD_W{1'b0}};
      end
    end else begin
      prod_pipe_r[0] <= prod_s;
      for (int i = 1; i < MUL_STAGES; i++) begin
        prod_pipe_r[i] <= prod_pipe_r[i-1];
      end
    end
  end

  // Normalise the product: [1,2) x [1,2) lies in [1,4), so at most one right shift.
  always_comb begin
    if (prod_out_s[PROD_W-1]) begin
      nrm_man_s = prod_out_s[47:24];
      nrm_g_s   = prod_out_s[23];
      nrm_s_s   = |prod_out_s[22:0];
      nrm_exp_s = exp_r + 10'sd1;
    end else begin
      nrm_man_s = prod_out_s[46:23];
      nrm_g_s   = prod_out_s[22];
      nrm_s_s   = |prod_out_s[21:0];
      nrm_exp_s = exp_r;
    end
  end

  fp32_round_rne u_round (
    .mant     (norm_man_r),
    .guard    (norm_g_r),
    .sticky   (norm_s_r),
    .exp_in   (norm_exp_r),
    .mant_out (rnd_man_s),
    .exp_out  (rnd_exp_s)
  );

  // Post-rounding range check: saturate to Inf or flush to zero.
  always_comb begin
    if (rnd_exp_s >= 10'sd255) begin
      final_res_s = {sign_r, EXP_MAX, 23'd0};
    end else if (rnd_exp_s <= 10'sd0) begin
      final_res_s = {sign_r, 31'd0};
    end else begin
      final_res_s = {sign_r, rnd_exp_s[7:0], rnd_man_s};
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      sign_r     <= 1'b0;
      exp_r      <= 10'sd0;
      mul_a_r    <= 24'd0;
      mul_b_r    <= 24'd0;
      cnt_r      <= 2'd0;
      norm_man_r <= 24'd0;
      norm_g_r   <= 1'b0;
      norm_s_r   <= 1'b0;
      norm_exp_r <= 10'sd0;
      res_next_r <= 32'd0;
      nan_next_r <= 1'b0;
      result_r   <= 32'd0;
      ready_r    <= 1'b0;
      nan_r      <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      nan_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (En) begin
            a_r     <= A;
            b_r     <= B;
            state_r <= CLASSIFY;
          end else begin
            state_r <= IDLE;
          end
        end
        CLASSIFY: begin
          sign_r <= a_r[31] ^ b_r[31];
          exp_r  <= exp_sum_s;
          if (special_s) begin
            res_next_r <= special_res_s;
            nan_next_r <= special_nan_s;
            state_r    <= PACK;
          end else begin
            state_r <= MUL_ISSUE;
          end
        end
        MUL_ISSUE: begin
          mul_a_r <= {1'b1, a_r[22:0]};
          mul_b_r <= {1'b1, b_r[22:0]};
          cnt_r   <= 2'd0;
          state_r <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= NORMALIZE;
          end else begin
            cnt_r <= cnt_r + 2'd1;
          end
        end
        NORMALIZE: begin
          norm_man_r <= nrm_man_s;
          norm_g_r   <= nrm_g_s;
          norm_s_r   <= nrm_s_s;
          norm_exp_r <= nrm_exp_s;
          state_r    <= ROUND;
        end
        ROUND: begin
          res_next_r <= final_res_s;
          nan_next_r <= 1'b0;
          state_r    <= PACK;
        end
        PACK: begin
          result_r <= res_next_r;
          nan_r    <= nan_next_r;
          ready_r  <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_multiplier.sv
// tb_fp32_multiplier: directed self-checking bench for fp32_multiplier.
//   Hand-computed vectors for normal, rounding, overflow, underflow and special
//   cases, a burst with En held high, and an abort by reset mid-operation.
module tb_fp32_multiplier;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        En;
  logic [31:0] Result;
  logic        Ready;
  logic        NaN;

  int n_checks;
  int n_fail;

  fp32_multiplier #(.MUL_STAGES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .En     (En),
    .Result (Result),
    .Ready  (Ready),
    .NaN    (NaN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  // Issue one request, wait (bounded) for Ready and check latency, result and flags.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic nan, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    A  = a;
    B  = b;
    En = 1'b1;
    @(posedge clk);
    #1;
    En = 1'b0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (Ready) break;
    end
    check_eq({tag, "_lat"}, 32'(n), 32'(lat));
    check_eq({tag, "_res"}, Result, res);
    check_eq({tag, "_nan"}, {31'd0, NaN}, {31'd0, nan});
    @(posedge clk);
    #1;
    check_eq({tag, "_rdy_low"}, {31'd0, Ready}, 32'd0);
    check_eq({tag, "_nan_low"}, {31'd0, NaN}, 32'd0);
  endtask

  logic [31:0] burst_a [3];
  logic [31:0] burst_b [3];
  logic [31:0] burst_r [3];
  int          exp_edge_q [$];
  logic [31:0] exp_res_q [$];

  initial begin
    int next_accept;
    int n_ready;
    logic exp_rdy;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    A     = 32'd0;
    B     = 32'd0;
    En    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_result", Result, 32'd0);
    check_eq("rst_ready", {31'd0, Ready}, 32'd0);
    check_eq("rst_nan", {31'd0, NaN}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Normal path, latency 5+2 = 7.
    run_op("mul_3x2",    32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 1'b0, 7);
    run_op("mul_1p5sq",  32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 7);
    run_op("mul_sticky", 32'h3FC0_0001, 32'h3F80_0001, 32'h3FC0_0003, 1'b0, 7);
    run_op("mul_ovf",    32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 7);
    run_op("mul_unf",    32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 7);
    run_op("mul_unf_neg",32'h8080_0000, 32'h0080_0000, 32'h8000_0000, 1'b0, 7);
    // Special cases, latency 2.
    run_op("inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1, 2);
    run_op("ninf_x_2",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 2);
    run_op("nan_in",     32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 2);
    run_op("zero_neg",   32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, 2);

    // En held high 20 edges with operands changing every cycle: accepts at
    // edges 0, 8, 16 (Ready 7 edges later, re-accept on the edge after Ready).
    burst_a[0] = 32'h4040_0000; burst_b[0] = 32'h4000_0000; burst_r[0] = 32'h40C0_0000;
    burst_a[1] = 32'h3FC0_0000; burst_b[1] = 32'h3FC0_0000; burst_r[1] = 32'h4010_0000;
    burst_a[2] = 32'hC040_0000; burst_b[2] = 32'h4000_0000; burst_r[2] = 32'hC0C0_0000;
    next_accept = 0;
    n_ready     = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      En = (k < 20);
      A  = burst_a[k % 3];
      B  = burst_b[k % 3];
      if (En && (k >= next_accept)) begin
        exp_edge_q.push_back(k + 7);
        exp_res_q.push_back(burst_r[k % 3]);
        next_accept = k + 8;
      end
      @(posedge clk);
      #1;
      exp_rdy = (exp_edge_q.size() > 0) && (exp_edge_q[0] == k);
      check_eq("burst_rdy", {31'd0, Ready}, {31'd0, exp_rdy});
      if (Ready) n_ready++;
      if (exp_rdy) begin
        check_eq("burst_res", Result, exp_res_q[0]);
        check_eq("burst_nan", {31'd0, NaN}, 32'd0);
        void'(exp_edge_q.pop_front());
        void'(exp_res_q.pop_front());
      end
    end
    En = 1'b0;
    check_eq("burst_count", 32'(n_ready), 32'd3);

    // Abort: reset during MUL_WAIT clears outputs at once and suppresses Ready.
    @(negedge clk);
    A  = 32'h4040_0000;
    B  = 32'h4000_0000;
    En = 1'b1;
    @(posedge clk);
    #1;
    En = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("abort_result", Result, 32'd0);
    check_eq("abort_ready", {31'd0, Ready}, 32'd0);
    check_eq("abort_nan", {31'd0, NaN}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    n_ready = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (Ready) n_ready++;
    end
    check_eq("abort_no_ready", 32'(n_ready), 32'd0);
    run_op("post_abort", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 1'b0, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_multiplier.md
Name: fp32_multiplier

Overview:
Multi-cycle IEEE-754 single-precision multiplier. It is the companion of the FP32 divider and sits beside it in the arithmetic unit. It uses the same A/B/En/Result/Ready/NaN handshake, so the unit's operation sequencer drives both blocks the same way. The mantissa product goes through a registered (DSP-mapped) 24x24 multiplier, then normalisation and round-to-nearest-even.

Parameters:
MUL_STAGES, 2, register stages in the 24x24 mantissa multiplier (1..3); normal-path latency tracks it.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
A  input  32  FP32 multiplicand, sampled when En=1 in IDLE
B  input  32  FP32 multiplier, sampled when En=1 in IDLE
En  input  1  start request; honoured only in IDLE
Result  output  32  FP32 product; holds until the next completion
Ready  output  1  one-cycle completion pulse; Result is valid in that cycle
NaN  output  1  high with Ready when Result is the canonical NaN

Behaviour:
Interface and reset:
- One clock domain, clk. reset is asynchronous and active-high.
- Reset values: Result=0x00000000, Ready=0, NaN=0, state=IDLE. Internal operand, product and multiplier registers are cleared.
- Reset asserted mid-operation aborts the operation. No Ready is issued for it.

Handshake:
- En is sampled only in IDLE. A and B are latched on that edge.
- En is ignored while busy. No queuing.
- Ready and NaN are high for exactly one cycle, then return to 0.
- A new En can be accepted on the edge after the Ready cycle, back-to-back.

States and transitions:
- IDLE: on En=1, go to CLASSIFY.
- CLASSIFY: on a special case, go to PACK. Otherwise go to MUL_ISSUE.
- MUL_ISSUE: load the multiplier operand registers.
- MUL_WAIT: count MUL_STAGES cycles.
- NORMALIZE, then ROUND, then PACK. PACK drives Ready and returns to IDLE.

Latency, counted from the En-sampling edge to the edge that raises Ready:
- Special cases: 2 edges.
- Normal path: 5+MUL_STAGES edges (7 at default).

Input classification:
- E=0xFF with M!=0 is NaN.
- E=0xFF with M=0 is Inf.
- E=0 is zero; subnormal inputs are flushed to zero.

Special-case priority, highest first:
1. Either operand NaN → Result 0x7FC00000, NaN=1.
2. Inf × zero, either order → 0x7FC00000, NaN=1.
3. Either operand Inf → {SA^SB, 0xFF, 0}.
4. Either operand zero → {SA^SB, 31'b0}.

Arithmetic (normal path):
- Mantissas: MA={1,A[22:0]}, MB={1,B[22:0]}, P=MA*MB (48 bits).
- Exponent: E = EA + EB − 127, held as a signed 10-bit value.
- If P[47]=1: mantissa M=P[46:24], guard G=P[23], sticky S=|P[22:0], and E=E+1.
- If P[47]=0: M=P[45:23], G=P[22], S=|P[21:0].

Rounding (RNE):
- Increment when G & (S | M[0]).
- If the increment carries out of the mantissa: M=0 and E=E+1.

Final range check after rounding:
- E ≥ 255 → {S, 0xFF, 0} (Inf).
- E ≤ 0 → {S, 31'b0} (flush to zero; no subnormal outputs).
- Otherwise → {S, E[7:0], M}.

Result sign S=SA^SB in every non-NaN case. The NaN sign is always 0.

Decomposition:
Shared package fp32_pkg:
- Field widths.
- BIAS=127 and EXP_MAX=8'hFF.
- QNAN=32'h7FC00000.
- A class enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN} and a classify function.

The state enum is local to the module.

Sub-module fp32_round_rne is combinational:
- Inputs: 24-bit mantissa, G, S, 10-bit exponent.
- Outputs: rounded 23-bit mantissa and adjusted exponent.
- The divider adopts it later.

The mantissa multiplier is instantiated inline as a MUL_STAGES-deep registered product with use_dsp.

Test Plan:
- A=0x40400000 (3.0), B=0x40000000 (2.0), En pulse → Ready on the 7th edge, Result=0x40C00000, NaN=0; Ready low on the next cycle.
- A=0x3FC00000, B=0x3FC00000 (1.5×1.5, P[47]=1 path) → 0x40100000. Then A=0x3FC00001, B=0x3F800001 → 0x3FC00003 (round up on sticky).
- A=0x7F000000, B=0x40000000 → 0x7F800000 (overflow). A=0x00800000, B=0x00800000 → 0x00000000 (underflow flush). A=0x80800000, B=0x00800000 → 0x80000000.
- A=0x7F800000, B=0x00000000 → 0x7FC00000 with NaN=1 at 2 edges. A=0xFF800000, B=0x40000000 → 0xFF800000, NaN=0. A=0x7FC00000, B=0x3F800000 → NaN=1.
- En held high for 20 cycles with varying A/B → exactly one Ready per accepted request, each Result matching the operands latched at acceptance. Ready never overlaps a busy re-sample.
- reset asserted during MUL_WAIT → Ready, NaN and Result go to 0 immediately, with no Ready pulse. After release, a new 3.0×2.0 request completes normally.
